// File: rtl/rr_arb4_if.sv
// Request/grant bundle between the four clients and the rr_arb4 round-robin arbiter.
// master = requester side (drives req/en), slave = arbiter side (drives grant outputs).
interface rr_arb4_if;
  logic [3:0] req;
  logic       en;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output en,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  en,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with held one-hot grant and rotating priority pointer.
// Define RR_ARB4_TIMEOUT_EN to add forced revocation after MAX_HOLD consecutive grant cycles.
module rr_arb4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_arb4_if.slave   bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
`ifdef RR_ARB4_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] scan_idx;

  // First requester at or after ptr, modulo 4; the pointer itself is the highest priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.en && win_found) begin
          state_d  = ST_GRANT;
          gnt_d    = 4'(4'b0001 << win_id);
          gnt_id_d = win_id;
          busy_d   = 1'b1;
`ifdef RR_ARB4_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          gnt_d    = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!bus.req[gnt_id_q]) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
          ptr_d    = gnt_id_q + 2'd1;
`ifdef RR_ARB4_TIMEOUT_EN
        end else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
          // Count holds (cycles already granted - 1); expiry is a revoke that looks like a release.
          state_d   = ST_IDLE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          busy_d    = 1'b0;
          ptr_d     = gnt_id_q + 2'd1;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
`ifdef RR_ARB4_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

  max_hold_legal: assert property (@(posedge clk) (MAX_HOLD >= 2) && (MAX_HOLD <= 255));
  gnt_onehot0:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

endmodule

// File: tb/tb_rr_arb4.sv
// Directed bench for rr_arb4: stimulus pushes hand-computed expectations, a monitor pops and compares each cycle.
// Build with RR_ARB4_TIMEOUT_EN to exercise revocation at MAX_HOLD=4.
module tb_rr_arb4;

  logic clk;
  logic rst_n;

  rr_arb4_if bus ();

  rr_arb4 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  bit   stim_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change on the falling edge; the expectation is what the outputs show after the next rising edge.
  task automatic step(input string tag, input logic r, input logic [3:0] rq, input logic e_n,
                      input logic [3:0] g, input logic [1:0] id, input logic b, input logic t);
    exp_t e;
    @(negedge clk);
    rst_n   = r;
    bus.req = rq;
    bus.en  = e_n;
    e.tag  = tag;
    e.gnt  = g;
    e.id   = id;
    e.busy = b;
    e.to   = t;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({bus.gnt, bus.gnt_id, bus.busy, bus.timeout} !== {e.gnt, e.id, e.busy, e.to}) begin
          bad++;
          $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                   e.tag, bus.gnt, bus.gnt_id, bus.busy, bus.timeout, e.gnt, e.id, e.busy, e.to);
        end
      end
    end
  end

  initial begin : stimulus
    total     = 0;
    bad       = 0;
    stim_done = 1'b0;
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.en    = 1'b0;

    step("reset0", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    step("reset1", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    // 1010 from ptr 0 -> owner 1; release hands next grant to 3 after one idle cycle
    step("t1_grant",   1, 4'b1010, 1, 4'b0010, 1, 1, 0);
    step("t1_hold2",   1, 4'b1010, 1, 4'b0010, 1, 1, 0);
    step("t1_hold3",   1, 4'b1010, 1, 4'b0010, 1, 1, 0);
    step("t1_release", 1, 4'b1000, 1, 4'b0000, 0, 0, 0);
    step("t1_next3",   1, 4'b1000, 1, 4'b1000, 3, 1, 0);
    step("t1_hold3b",  1, 4'b1000, 1, 4'b1000, 3, 1, 0);

    // owner 3 releases: ptr wraps to 0
    step("wrap_rel",   1, 4'b0001, 1, 4'b0000, 0, 0, 0);
    step("wrap_gnt0",  1, 4'b1001, 1, 4'b0001, 0, 1, 0);
    step("wrap_hold",  1, 4'b1001, 1, 4'b0001, 0, 1, 0);
    step("wrap_rel0",  1, 4'b1000, 1, 4'b0000, 0, 0, 0);
    step("wrap_gnt3",  1, 4'b1000, 1, 4'b1000, 3, 1, 0);
    step("wrap_rel3",  1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    step("idle",       1, 4'b0000, 1, 4'b0000, 0, 0, 0);

    // all four requesting, each drops for one cycle after two grant cycles
    step("rr_g0",   1, 4'b1111, 1, 4'b0001, 0, 1, 0);
    step("rr_h0",   1, 4'b1111, 1, 4'b0001, 0, 1, 0);
    step("rr_r0",   1, 4'b1110, 1, 4'b0000, 0, 0, 0);
    step("rr_g1",   1, 4'b1111, 1, 4'b0010, 1, 1, 0);
    step("rr_h1",   1, 4'b1111, 1, 4'b0010, 1, 1, 0);
    step("rr_r1",   1, 4'b1101, 1, 4'b0000, 0, 0, 0);
    step("rr_g2",   1, 4'b1111, 1, 4'b0100, 2, 1, 0);
    step("rr_h2",   1, 4'b1111, 1, 4'b0100, 2, 1, 0);
    step("rr_r2",   1, 4'b1011, 1, 4'b0000, 0, 0, 0);
    step("rr_g3",   1, 4'b1111, 1, 4'b1000, 3, 1, 0);
    step("rr_h3",   1, 4'b1111, 1, 4'b1000, 3, 1, 0);
    step("rr_r3",   1, 4'b0111, 1, 4'b0000, 0, 0, 0);
    step("rr_g0b",  1, 4'b1111, 1, 4'b0001, 0, 1, 0);
    step("rr_r0b",  1, 4'b1110, 1, 4'b0000, 0, 0, 0);
    step("rr_idle", 1, 4'b0000, 1, 4'b0000, 0, 0, 0);

    // en=0 blocks arbitration; dropping en while granted has no effect
    for (int i = 0; i < 5; i++) step("en_block", 1, 4'b0100, 0, 4'b0000, 0, 0, 0);
    step("en_raise",   1, 4'b0100, 1, 4'b0100, 2, 1, 0);
    step("en_drop",    1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step("en_others",  1, 4'b1111, 0, 4'b0100, 2, 1, 0);
    step("en_release", 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    step("en_keepptr", 1, 4'b0001, 0, 4'b0000, 0, 0, 0);
    step("ptr3_scan",  1, 4'b0011, 1, 4'b0001, 0, 1, 0);
    step("ptr3_hold",  1, 4'b0011, 1, 4'b0001, 0, 1, 0);

`ifdef RR_ARB4_TIMEOUT_EN
    step("to_hold3",  1, 4'b0011, 1, 4'b0001, 0, 1, 0);
    step("to_hold4",  1, 4'b0011, 1, 4'b0001, 0, 1, 0);
    step("to_revoke", 1, 4'b0011, 1, 4'b0000, 0, 0, 1);
    step("to_next1",  1, 4'b0011, 1, 4'b0010, 1, 1, 0);
    step("to_hold1",  1, 4'b0011, 1, 4'b0010, 1, 1, 0);
    step("rst_mid",   0, 4'b0011, 1, 4'b0000, 0, 0, 0);
`else
    for (int i = 0; i < 10; i++) step("hold_long", 1, 4'b0011, 1, 4'b0001, 0, 1, 0);
    step("rst_mid",   0, 4'b0011, 1, 4'b0000, 0, 0, 0);
`endif
    // after reset ptr=0: 1001 must go to 0, not 3
    step("rst_resume", 1, 4'b1001, 1, 4'b0001, 0, 1, 0);
    step("rst_hold",   1, 4'b1001, 1, 4'b0001, 0, 1, 0);
    step("end_rel",    1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    step("end_idle",   1, 4'b0000, 1, 4'b0000, 0, 0, 0);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    if (!stim_done) begin
      $display("FAIL watchdog: got no completion by 100000 time units, want completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
